// File: rtl/cv32e41s_sffr_ctrl.sv
// rtl/cv32e41s_sffr_ctrl.sv - duplicated (value/~shadow) register bank with RR write arbiter and scrub FSM
// Optional read-port integrity check: define CV32E41S_SFFR_CTRL_READ_CHECK_EN.
module cv32e41s_sffr_ctrl #(
  parameter int NUM_REGS    = 8,
  parameter int WIDTH       = 32,
  parameter int NUM_REQ     = 2,
  parameter int SCAN_PERIOD = 64,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       wreq_i,
  input  logic [NUM_REQ*AW-1:0]    waddr_i,
  input  logic [NUM_REQ*WIDTH-1:0] wdata_i,
  output logic [NUM_REQ-1:0]       wgnt_o,
  input  logic [AW-1:0]            raddr_i,
  output logic [WIDTH-1:0]         rdata_o,
  input  logic                     scan_req_i,
  output logic                     scan_busy_o,
  output logic                     alert_major_o,
  output logic [AW-1:0]            err_idx_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  logic [NUM_REGS-1:0][WIDTH-1:0] value_q, value_d;
  logic [NUM_REGS-1:0][WIDTH-1:0] shadow_q, shadow_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             scan_busy_q, scan_busy_d;
  logic             alert_q, alert_d;
  logic [AW-1:0]    err_idx_q, err_idx_d;

  int               gnt_idx;
  logic             gnt_any;
  logic [AW-1:0]    waddr_sel;
  logic [WIDTH-1:0] wdata_sel;
  logic             wen;
  logic             collide;
  logic             mismatch;
  logic             scrub_err;
  logic             rd_in_range;
  logic             rd_err;

  // Lowest asserted requester at or above the pointer wins; otherwise wrap to the lowest overall.
  always_comb begin
    gnt_idx = 0;
    gnt_any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (wreq_i[i]) begin
        gnt_idx = i;
        gnt_any = 1'b1;
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (wreq_i[i] && (i >= int'(ptr_q))) gnt_idx = i;
    end
  end

  always_comb begin
    wgnt_o    = '0;
    waddr_sel = '0;
    wdata_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_any && (gnt_idx == i)) begin
        wgnt_o[i] = 1'b1;
        waddr_sel = waddr_i[i*AW +: AW];
        wdata_sel = wdata_i[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (gnt_idx == NUM_REQ - 1) ? '0 : PW'(gnt_idx + 1);
  end

  assign wen = gnt_any && (32'(waddr_sel) < NUM_REGS);

  always_comb begin
    value_d  = value_q;
    shadow_d = shadow_q;
    if (wen) begin
      value_d[waddr_sel]  = wdata_sel;
      shadow_d[waddr_sel] = ~wdata_sel;
    end
  end

  assign rd_in_range = 32'(raddr_i) < NUM_REGS;
  assign rdata_o     = rd_in_range ? value_q[raddr_i] : '0;

  // A write landing on the entry under test defers its compare by one cycle.
  assign collide  = wen && (waddr_sel == idx_q);
  assign mismatch = value_q[idx_q] != ~shadow_q[idx_q];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    scrub_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (scan_req_i || (32'(cnt_q) == SCAN_PERIOD - 1)) begin
          state_d = SCAN;
          idx_d   = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SCAN: begin
        if (!collide) begin
          scrub_err = mismatch;
          if (32'(idx_q) == NUM_REGS - 1) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign scan_busy_d = (state_d == SCAN);

`ifdef CV32E41S_SFFR_CTRL_READ_CHECK_EN
  assign rd_err = rd_in_range && (value_q[raddr_i] != ~shadow_q[raddr_i]);
`else
  assign rd_err = 1'b0;
`endif

  always_comb begin
    alert_d   = alert_q | scrub_err | rd_err;
    err_idx_d = err_idx_q;
    if (!alert_q) begin
      if (scrub_err)   err_idx_d = idx_q;
      else if (rd_err) err_idx_d = raddr_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q     <= '0;
      shadow_q    <= '1;
      ptr_q       <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      scan_busy_q <= 1'b0;
      alert_q     <= 1'b0;
      err_idx_q   <= '0;
    end else begin
      value_q     <= value_d;
      shadow_q    <= shadow_d;
      ptr_q       <= ptr_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      scan_busy_q <= scan_busy_d;
      alert_q     <= alert_d;
      err_idx_q   <= err_idx_d;
    end
  end

  assign scan_busy_o   = scan_busy_q;
  assign alert_major_o = alert_q;
  assign err_idx_o     = err_idx_q;

endmodule

// File: tb/tb_cv32e41s_sffr_ctrl.sv
// tb/tb_cv32e41s_sffr_ctrl.sv - directed self-checking bench for cv32e41s_sffr_ctrl
module tb_cv32e41s_sffr_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  wreq_i = '0;
  logic [5:0]  waddr_i = '0;
  logic [63:0] wdata_i = '0;
  logic [1:0]  wgnt_o;
  logic [2:0]  raddr_i = '0;
  logic [31:0] rdata_o;
  logic        scan_req_i = 1'b0;
  logic        scan_busy_o;
  logic        alert_major_o;
  logic [2:0]  err_idx_o;

  logic [7:0][31:0] sh;
  int n_pass = 0;
  int n_total = 0;

  cv32e41s_sffr_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .wreq_i(wreq_i), .waddr_i(waddr_i), .wdata_i(wdata_i), .wgnt_o(wgnt_o),
    .raddr_i(raddr_i), .rdata_o(rdata_o),
    .scan_req_i(scan_req_i), .scan_busy_o(scan_busy_o),
    .alert_major_o(alert_major_o), .err_idx_o(err_idx_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wreq_i = '0;
    scan_req_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    raddr_i = 3'd4;
    #1;
    check("rst_wgnt", 32'(wgnt_o), 32'h0);
    check("rst_busy", 32'(scan_busy_o), 32'h0);
    check("rst_alert", 32'(alert_major_o), 32'h0);
    check("rst_err_idx", 32'(err_idx_o), 32'h0);
    check("rst_rdata", rdata_o, 32'h0);

    // single write, requester 0
    wreq_i = 2'b01; waddr_i = {3'd0, 3'd3}; wdata_i = {32'h0, 32'hDEADBEEF}; raddr_i = 3'd3;
    #1;
    check("wr_gnt", 32'(wgnt_o), 32'h1);
    check("wr_rdata_before", rdata_o, 32'h0);
    step();
    wreq_i = '0;
    #1;
    check("wr_rdata_after", rdata_o, 32'hDEADBEEF);
    check("wr_alert", 32'(alert_major_o), 32'h0);

    // round-robin with both requesters held
    do_reset();
    wreq_i = 2'b11; waddr_i = {3'd2, 3'd1}; wdata_i = {32'hBBBB_0002, 32'hAAAA_0001};
    #1; check("rr_gnt0", 32'(wgnt_o), 32'h1); step();
    #1; check("rr_gnt1", 32'(wgnt_o), 32'h2); step();
    #1; check("rr_gnt2", 32'(wgnt_o), 32'h1); step();
    #1; check("rr_gnt3", 32'(wgnt_o), 32'h2); step();
    wreq_i = '0;
    raddr_i = 3'd1; #1; check("rr_rd1", rdata_o, 32'hAAAA_0001);
    raddr_i = 3'd2; #1; check("rr_rd2", rdata_o, 32'hBBBB_0002);
    check("rr_gnt_idle", 32'(wgnt_o), 32'h0);

    // automatic scrub timing
    do_reset();
    repeat (63) step();
    check("per_busy_c63", 32'(scan_busy_o), 32'h0);
    step();
    check("per_busy_c64", 32'(scan_busy_o), 32'h1);
    repeat (7) step();
    check("per_busy_c71", 32'(scan_busy_o), 32'h1);
    step();
    check("per_busy_c72", 32'(scan_busy_o), 32'h0);
    check("per_alert", 32'(alert_major_o), 32'h0);

    // shadow[5] corruption found by forced scrub
    do_reset();
    raddr_i = 3'd3;
    sh = '1;
    sh[5][0] = 1'b0;
    force dut.shadow_q = sh;
    scan_req_i = 1'b1;
    step();
    scan_req_i = 1'b0;
    check("cor_busy", 32'(scan_busy_o), 32'h1);
    repeat (5) step();
    check("cor_alert_pre", 32'(alert_major_o), 32'h0);
    step();
    check("cor_alert", 32'(alert_major_o), 32'h1);
    check("cor_err_idx", 32'(err_idx_o), 32'h5);
    repeat (2) step();
    check("cor_busy_end", 32'(scan_busy_o), 32'h0);
    release dut.shadow_q;
    wreq_i = 2'b01; waddr_i = {3'd0, 3'd5}; wdata_i = {32'h0, 32'h12345678};
    #1; check("cor_wr_gnt", 32'(wgnt_o), 32'h1);
    step();
    wreq_i = '0; raddr_i = 3'd5;
    #1;
    check("cor_rdata", rdata_o, 32'h12345678);
    check("cor_alert_sticky", 32'(alert_major_o), 32'h1);
    check("cor_err_sticky", 32'(err_idx_o), 32'h5);
    do_reset();
    #1;
    check("cor_alert_cleared", 32'(alert_major_o), 32'h0);

    // write collides with the entry being scrubbed
    do_reset();
    scan_req_i = 1'b1;
    step();
    scan_req_i = 1'b0;
    step();
    step();
    wreq_i = 2'b01; waddr_i = {3'd0, 3'd2}; wdata_i = {32'h0, 32'hA5A5_0F0F};
    #1; check("col_gnt", 32'(wgnt_o), 32'h1);
    step();
    wreq_i = '0;
    repeat (5) step();
    check("col_busy_c8", 32'(scan_busy_o), 32'h1);
    step();
    check("col_busy_c9", 32'(scan_busy_o), 32'h0);
    check("col_alert", 32'(alert_major_o), 32'h0);
    raddr_i = 3'd2; #1;
    check("col_rdata", rdata_o, 32'hA5A5_0F0F);

    // read-port check on corrupted shadow[2]
    do_reset();
    sh = '1;
    sh[2][7] = 1'b0;
    force dut.shadow_q = sh;
    raddr_i = 3'd2;
    step();
`ifdef CV32E41S_SFFR_CTRL_READ_CHECK_EN
    check("rd_alert", 32'(alert_major_o), 32'h1);
    check("rd_err_idx", 32'(err_idx_o), 32'h2);
`else
    check("rd_alert", 32'(alert_major_o), 32'h0);
    check("rd_err_idx", 32'(err_idx_o), 32'h0);
`endif
    raddr_i = 3'd0;
    scan_req_i = 1'b1;
    step();
    scan_req_i = 1'b0;
    repeat (3) step();
    check("rd_scrub_alert", 32'(alert_major_o), 32'h1);
    check("rd_scrub_err_idx", 32'(err_idx_o), 32'h2);
    release dut.shadow_q;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
